// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: grants one sprite drawer at a time and rasters its SIZExSIZE block onto the VGA plot port.
// Define VGA_PLOT_ARB_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module vga_plot_arbiter #(
  parameter int N_REQ = 4,
  parameter int SIZE  = 4,
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_x,
  input  logic [7*N_REQ-1:0] req_y,
  input  logic [3*N_REQ-1:0] req_colour,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic [7:0]         x,
  output logic [6:0]         y,
  output logic [2:0]         colour,
  output logic               plot
);
  localparam int L  = SIZE > 1 ? $clog2(SIZE) : 1;
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam logic [2*L-1:0] LAST = (2*L)'(SIZE*SIZE-1);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DRAW = 2'd2, DONE = 2'd3;
  logic [1:0]    r_st;
  logic [IW-1:0] r_win;
  logic [7:0]    r_bx;
  logic [6:0]    r_by;
  logic [2:0]    r_col;
  logic [2*L-1:0] r_cnt;
  logic [IW-1:0] w_win;
  logic [7:0]    w_bx;
  logic [6:0]    w_by;
  logic [2:0]    w_col;
  logic [2*L-1:0] w_cnt;
  logic [8:0]    w_sx;
  logic [7:0]    w_sy;
  logic          w_ok;
`ifdef VGA_PLOT_ARB_RR_EN
  logic [IW-1:0] r_ptr;
`endif
  always_comb begin
    w_win = '0;
`ifdef VGA_PLOT_ARB_RR_EN
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[(int'(r_ptr) + k) % N_REQ]) w_win = IW'((int'(r_ptr) + k) % N_REQ);
`else
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[i]) w_win = IW'(i);
`endif
  end
  // Outputs are registered, so the next pixel is computed from the LOAD-time inputs or the latched base.
  assign w_bx  = r_st == LOAD ? req_x[8*r_win +: 8] : r_bx;
  assign w_by  = r_st == LOAD ? req_y[7*r_win +: 7] : r_by;
  assign w_col = r_st == LOAD ? req_colour[3*r_win +: 3] : r_col;
  assign w_cnt = r_st == LOAD ? '0 : r_cnt + 1'b1;
  assign w_sx  = {1'b0, w_bx} + 9'(w_cnt[L-1:0]);
  assign w_sy  = {1'b0, w_by} + 8'(w_cnt[2*L-1:L]);
  assign w_ok  = w_sx < 9'(X_MAX) && w_sy < 8'(Y_MAX);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st   <= IDLE;
      r_win  <= '0;
      r_bx   <= '0;
      r_by   <= '0;
      r_col  <= '0;
      r_cnt  <= '0;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
`ifdef VGA_PLOT_ARB_RR_EN
      r_ptr  <= '0;
`endif
    end else begin
      case (r_st)
        IDLE: if (|req) begin
          r_st  <= LOAD;
          r_win <= w_win;
          grant <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
          busy  <= 1'b1;
`ifdef VGA_PLOT_ARB_RR_EN
          r_ptr <= IW'((int'(w_win) + 1) % N_REQ);
`endif
        end
        LOAD: begin
          r_st   <= DRAW;
          r_bx   <= w_bx;
          r_by   <= w_by;
          r_col  <= w_col;
          r_cnt  <= w_cnt;
          x      <= w_sx[7:0];
          y      <= w_sy[6:0];
          colour <= w_col;
          plot   <= w_ok;
        end
        DRAW: if (r_cnt == LAST) begin
          r_st  <= DONE;
          plot  <= 1'b0;
          done  <= grant;
          grant <= '0;
        end else begin
          r_cnt <= w_cnt;
          x     <= w_sx[7:0];
          y     <= w_sy[6:0];
          plot  <= w_ok;
        end
        DONE: begin
          r_st <= IDLE;
          done <= '0;
          busy <= 1'b0;
        end
        default: r_st <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Shares the single VGA adapter plot port among several sprite drawers (player, bees, erase/clear). Each requester asks for one SIZE×SIZE block at a base (x, y) in one colour. The arbiter grants one requester at a time and walks every pixel of that block onto `x`/`y`/`colour`/`plot`, one pixel per clock. It sits between the per-object datapath/control pairs and the `vga_adapter` instance at top level.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2–8)
- `SIZE`, 4, block edge length in pixels; must be a power of two (1–8)
- `X_MAX`, 160, screen width; pixels with x ≥ X_MAX are clipped
- `Y_MAX`, 120, screen height; pixels with y ≥ Y_MAX are clipped

Ports:
- `clk`, in, 1: system clock (CLOCK_50 at top level)
- `reset`, in, 1: asynchronous, active-high reset
- `req`, in, N_REQ: per-requester draw request, level-sensitive
- `req_x`, in, 8·N_REQ: base x per requester; requester i uses bits [8i+7:8i]
- `req_y`, in, 7·N_REQ: base y per requester; requester i uses bits [7i+6:7i]
- `req_colour`, in, 3·N_REQ: colour per requester; requester i uses bits [3i+2:3i]
- `grant`, out, N_REQ: one-hot; identifies the requester being served
- `done`, out, N_REQ: one-cycle pulse to the requester whose block has finished
- `busy`, out, 1: high in every state except IDLE
- `x`, out, 8: pixel x to `vga_adapter`
- `y`, out, 7: pixel y to `vga_adapter`
- `colour`, out, 3: pixel colour to `vga_adapter`
- `plot`, out, 1: write enable to `vga_adapter`

## Operation
- State machine: IDLE → LOAD → DRAW → DONE → IDLE.
- **IDLE**
  - If `req` is non-zero, select a winner (see Configuration), register its one-hot `grant`, and go to LOAD.
  - Otherwise remain in IDLE.
- **LOAD**
  - Latch the winner's base x, base y and colour into internal registers.
  - Clear `dx` and `dy` to 0. Go to DRAW.
- **DRAW**
  - Every cycle: `x = base_x + dx`, `y = base_y + dy`, `colour` = latched colour.
  - Pixel order is raster: `dx` increments fastest; when `dx` wraps from SIZE−1 to 0, `dy` increments.
  - After the pixel at (SIZE−1, SIZE−1), go to DONE. DRAW lasts exactly SIZE² cycles.
- **DONE**
  - `grant` drops to 0.
  - `done[winner]` is 1 for this cycle only.
  - Go to IDLE.
- Arithmetic and clipping:
  - Sums are formed one bit wider than the output (9-bit x, 8-bit y).
  - `plot` is 1 only when the state is DRAW, sum_x < X_MAX and sum_y < Y_MAX.
  - A clipped pixel still consumes its cycle; `x`/`y` carry the truncated sum, and `plot` is 0.
- Inputs are sampled only at defined points:
  - `req` is sampled only in IDLE.
  - `req_x`, `req_y` and `req_colour` are sampled only in LOAD.
  - Changing these inputs at any other time has no effect on the block in progress.
- Requester behaviour:
  - A requester holds `req` until it sees its `done` pulse.
  - If `req` drops mid-block, the block still completes and `done` still pulses.
  - If `req` is still high in the IDLE cycle after `done`, that is a new request and it is arbitrated normally.
- Reset during any state:
  - State returns to IDLE; `dx` and `dy` return to 0.
  - Outputs return to reset values immediately; no partial `done` is issued.
- Reset values: `grant` = 0, `done` = 0, `busy` = 0, `x` = 0, `y` = 0, `colour` = 0, `plot` = 0. Round-robin pointer = requester 0 has highest priority.

## Timing
- All outputs are registered.
- Let cycle 0 be the IDLE cycle in which `req` is seen:
  - `grant` and `busy` go high at cycle 1 (LOAD).
  - The first `plot` is at cycle 2.
  - The last `plot` is at cycle SIZE²+1.
  - `done` pulses at cycle SIZE²+2.
  - The block is in IDLE at cycle SIZE²+3.
- Worst-case service period is SIZE²+3 cycles (19 at SIZE=4). A back-to-back grant follows `done` by 2 cycles.
- `grant` is constant from LOAD through the last DRAW cycle.
- `plot` is never high outside DRAW.

## Configuration
- Macro: `VGA_PLOT_ARB_RR_EN`.
- **Defined:** round-robin arbitration.
  - The search starts at (last winner + 1) mod N_REQ.
  - The pointer updates when the grant is issued.
  - A requester holding `req` is served within N_REQ grants.
- **Undefined:** fixed priority; the lowest index wins. There is no pointer register.
- Everything else is identical in both builds.

## Test plan
- **Single request, SIZE=4:** req=0001, base (10, 20), colour 3'b101.
  - 16 plots, raster order: (10,20), (11,20) … (13,23).
  - `grant` = 0001 during cycles 1–17; `done[0]` pulses at cycle 18.
- **Clipping:** base (158, 118).
  - `plot` is high only for (158,118), (159,118), (158,119), (159,119).
  - The block still takes 16 DRAW cycles.
- **Contention, RR_EN defined:** req=1111 held high.
  - Grant order is 0001, 0010, 0100, 1000, 0001.
  - Undefined build: requester 0 is regranted every time.
- **Input change mid-block:** change `req_x` and `req_colour` of the winner, and drop `req`, during DRAW.
  - The block completes with the originally latched values; `done` still pulses.
- **Reset mid-DRAW:** assert `reset` at the 5th pixel.
  - All outputs go to 0 asynchronously; no `done` pulse.
  - After release with req=0010: a fresh 16-pixel block for requester 1.
